// File: rtl/aes_pkg.sv
// +----------------------------------------------------------------------+
// | aes_pkg                                                              |
// | Shared AES types, FSM encoding and GF(2^8) helpers for MixColumns.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

    localparam logic [7:0] c_aes_poly = 8'h1B;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_st_idle,
        ST_BUSY = c_st_busy,
        ST_DONE = c_st_done
    } state_e;

    typedef logic [31:0] col_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? c_aes_poly : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mix_column32.sv
// +----------------------------------------------------------------------+
// | mix_column32                                                         |
// | Combinational forward AES MixColumns of one 32-bit column.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mix_column32
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [7:0] w_a0, w_a1, w_a2, w_a3;

    assign w_a0 = i_col[31:24];
    assign w_a1 = i_col[23:16];
    assign w_a2 = i_col[15:8];
    assign w_a3 = i_col[7:0];

    assign o_col = {
        xtime(w_a0) ^ mul3(w_a1) ^ w_a2        ^ w_a3,
        w_a0        ^ xtime(w_a1) ^ mul3(w_a2) ^ w_a3,
        w_a0        ^ w_a1        ^ xtime(w_a2) ^ mul3(w_a3),
        mul3(w_a0)  ^ w_a1        ^ w_a2        ^ xtime(w_a3)
    };

endmodule

`default_nettype wire

// File: rtl/mix_columns_seq.sv
// +----------------------------------------------------------------------+
// | mix_columns_seq                                                      |
// | Handshaked AES MixColumns over a 128-bit state, one column per cycle;|
// | MIX_COLUMNS_SEQ_FAST_EN computes all four columns in a single cycle. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mix_columns_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out
);

    state_e       r_fsm;
    logic [127:0] r_state;
    logic [127:0] r_out;

    assign in_ready  = (r_fsm == ST_IDLE);
    assign out_valid = (r_fsm == ST_DONE);
    assign out       = r_out;

`ifdef MIX_COLUMNS_SEQ_FAST_EN
    logic [127:0] w_mixed;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_col
            mix_column32 u_mix (
                .i_col (r_state[127-32*g -: 32]),
                .o_col (w_mixed[127-32*g -: 32])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= ST_IDLE;
            r_state <= 128'h0;
            r_out   <= 128'h0;
        end else begin
            case (r_fsm)
                ST_IDLE: if (in_valid) begin
                    r_state <= in;
                    r_fsm   <= ST_BUSY;
                end
                ST_BUSY: begin
                    r_out <= w_mixed;
                    r_fsm <= ST_DONE;
                end
                ST_DONE: if (out_ready) r_fsm <= ST_IDLE;
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end
`else
    logic [1:0] r_cnt;
    col_t       w_col_in;
    col_t       w_col_out;

    // Column 0 is the most significant word of the state.
    always_comb begin
        w_col_in = r_state[127:96];
        case (r_cnt)
            2'd0: w_col_in = r_state[127:96];
            2'd1: w_col_in = r_state[95:64];
            2'd2: w_col_in = r_state[63:32];
            2'd3: w_col_in = r_state[31:0];
            default: w_col_in = r_state[127:96];
        endcase
    end

    mix_column32 u_mix (
        .i_col (w_col_in),
        .o_col (w_col_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_state <= 128'h0;
            r_out   <= 128'h0;
        end else begin
            case (r_fsm)
                ST_IDLE: if (in_valid) begin
                    r_state <= in;
                    r_cnt   <= 2'd0;
                    r_fsm   <= ST_BUSY;
                end
                ST_BUSY: begin
                    case (r_cnt)
                        2'd0: r_out[127:96] <= w_col_out;
                        2'd1: r_out[95:64]  <= w_col_out;
                        2'd2: r_out[63:32]  <= w_col_out;
                        2'd3: r_out[31:0]   <= w_col_out;
                        default: r_out[127:96] <= w_col_out;
                    endcase
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) r_fsm <= ST_DONE;
                end
                ST_DONE: if (out_ready) r_fsm <= ST_IDLE;
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
// +----------------------------------------------------------------------+
// | tb_mix_columns_seq                                                   |
// | Directed and throttled random checks of mix_columns_seq.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mix_columns_seq;

`ifdef MIX_COLUMNS_SEQ_FAST_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] INV_IN   = 128'hc6c6c6c6_d4d4d4d5_01010101_00000000;
    localparam logic [127:0] INV_OUT  = 128'hc6c6c6c6_d5d5d7d6_01010101_00000000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_data)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Shift-and-add GF(2^8) multiply, independent of the xtime formulation.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        logic       hi;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y  = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a [4];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[127-32*c-8*i -: 8];
            for (int i = 0; i < 4; i++)
                r[127-32*c-8*i -: 8] = gmul(a[i], 8'h02) ^ gmul(a[(i+1)%4], 8'h03)
                                     ^ a[(i+2)%4] ^ a[(i+3)%4];
        end
        return r;
    endfunction

    // One block: in_valid/in are scrambled while busy, output held for `hold` cycles.
    task automatic run_block(input string tag, input logic [127:0] data,
                             input logic [127:0] exp, input int hold);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = data;
        @(negedge clk);
        check_bit({tag, "_in_ready_idle"}, in_ready, 1'b1);
        @(posedge clk);
        for (int k = 0; k <= LAT; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            @(negedge clk);
            check_bit({tag, "_latency"}, out_valid, (k == LAT));
        end
        in_valid = 1'b0;
        check({tag, "_data"}, out_data, exp);
        check_bit({tag, "_in_ready_done"}, in_ready, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            in_data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check_bit({tag, "_hold_valid"}, out_valid, 1'b1);
            check({tag, "_hold_data"}, out_data, exp);
            check_bit({tag, "_hold_in_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_bit({tag, "_post_valid"}, out_valid, 1'b0);
        check_bit({tag, "_post_in_ready"}, in_ready, 1'b1);
    endtask

    logic [127:0] q [$];
    int           sent;
    int           recv;
    int           cyc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_bit("reset_in_ready", in_ready, 1'b1);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check("reset_out", out_data, 128'h0);

        run_block("fips", FIPS_IN, FIPS_OUT, 0);
        run_block("invariant_bp", INV_IN, INV_OUT, 10);

        // Abort during the second busy cycle.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = FIPS_IN;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out", out_data, 128'h0);
        check_bit("abort_out_valid", out_valid, 1'b0);
        check_bit("abort_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_bit("abort_no_result", out_valid, 1'b0);
        end

        run_block("recover", FIPS_IN, FIPS_OUT, 2);

        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 1000 && cyc < 40000) begin
            @(posedge clk); #1;
            cyc++;
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back(mix_model(in_data));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) check_bit("rand_extra_block", out_valid, 1'b0);
                else check("rand_data", out_data, q.pop_front());
                recv++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_int("rand_received", recv, 1000);
        check_int("rand_pending", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
